// File: rtl/core_pkg.sv
// Shared definitions for the Thumb core: micro-op codes, sequencer states
// and fault codes used by the sequencer and Decode.
package core_pkg;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_STR = 5'd9;
  localparam logic [4:0] UOP_LDR = 5'd10;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_UNDEF    = 2'd1;
  localparam logic [1:0] FC_FETCH_TO = 2'd2;
  localparam logic [1:0] FC_MEM_TO   = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_e;

  // ALU micro-ops that write a result register and the flags.
  function automatic logic uop_is_alu_wb(input logic [4:0] uop);
    logic hit;
    case (uop)
      UOP_ADD, UOP_SUB, UOP_EOR, UOP_LSL, UOP_MOV: hit = 1'b1;
      default:                                     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ack_timeout.sv
// 8-bit wait counter for a req/ack handshake; flags expiry at LIMIT wait cycles.
module ack_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LIMIT_C);

  // Clear dominates; counting stops once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM of the Thumb core: instruction fetch, decode hand-off,
// ALU/regfile/dmem strobe sequencing, PC ownership and fault capture.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
  output logic [15:0] instr,
  input  logic [4:0]  dec_uop,
  input  logic        dec_explose,
  output logic        alu_en,
  output logic        rf_we,
  output logic        flags_we,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        retire,
  output logic        idle,
  output logic        fault,
  output logic [1:0]  fault_code
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic        mem_we_q, mem_we_d;
  logic        fetch_busy_q, fetch_busy_d;

  logic        fetch_req_s, mem_req_s, alu_en_s, rf_we_s, flags_we_s, retire_s, idle_s;
  logic        tmo_clear_s, tmo_en_s, tmo_expired_s;
  logic [31:0] pc_inc_s;

  assign pc_inc_s = pc_q + 32'd2;

  // Next-state, PC and strobe decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    fault_code_d = fault_code_q;
    mem_we_d     = mem_we_q;
    fetch_req_s  = 1'b0;
    mem_req_s    = 1'b0;
    alu_en_s     = 1'b0;
    rf_we_s      = 1'b0;
    flags_we_s   = 1'b0;
    retire_s     = 1'b0;
    idle_s       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // Once issued, a fetch stays up regardless of run.
        if (run || fetch_busy_q) begin
          fetch_req_s = 1'b1;
          if (fetch_ack) begin
            instr_d = fetch_data;
            state_d = ST_DECODE;
          end else if (tmo_expired_s) begin
            fault_code_d = FC_FETCH_TO;
            state_d      = ST_FAULT;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          idle_s = 1'b1;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_explose) begin
          fault_code_d = FC_UNDEF;
          state_d      = ST_FAULT;
        end else if (uop_is_alu_wb(dec_uop)) begin
          alu_en_s   = 1'b1;
          rf_we_s    = 1'b1;
          flags_we_s = 1'b1;
          retire_s   = 1'b1;
          pc_d       = pc_inc_s;
          state_d    = ST_FETCH;
        end else begin
          case (dec_uop)
            UOP_CMP: begin
              alu_en_s   = 1'b1;
              flags_we_s = 1'b1;
              retire_s   = 1'b1;
              pc_d       = pc_inc_s;
              state_d    = ST_FETCH;
            end
            UOP_STR, UOP_LDR: begin
              alu_en_s = 1'b1;
              mem_we_d = (dec_uop == UOP_STR);
              state_d  = ST_MEM;
            end
            UOP_NOP: begin
              retire_s = 1'b1;
              pc_d     = branch_taken ? {branch_target[31:1], 1'b0} : pc_inc_s;
              state_d  = ST_FETCH;
            end
            default: begin
              fault_code_d = FC_UNDEF;
              state_d      = ST_FAULT;
            end
          endcase
        end
      end
      ST_MEM: begin
        mem_req_s = 1'b1;
        if (mem_ack) begin
          if (mem_we_q) begin
            retire_s = 1'b1;
            pc_d     = pc_inc_s;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_expired_s) begin
          fault_code_d = FC_MEM_TO;
          state_d      = ST_FAULT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we_s  = 1'b1;
        retire_s = 1'b1;
        pc_d     = pc_inc_s;
        state_d  = ST_FETCH;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        fault_code_d = FC_UNDEF;
        state_d      = ST_FAULT;
      end
    endcase
    fetch_busy_d = (state_d == ST_FETCH) && fetch_req_s;
  end

  // The wait counter restarts on every state change and counts unanswered requests.
  assign tmo_clear_s = (state_d != state_q);
  assign tmo_en_s    = (fetch_req_s && !fetch_ack) || (mem_req_s && !mem_ack);

  ack_timeout #(
    .LIMIT(MEM_TIMEOUT)
  ) u_ack_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmo_clear_s),
    .en_i     (tmo_en_s),
    .expired_o(tmo_expired_s)
  );

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 16'h0000;
      fault_code_q <= FC_NONE;
      mem_we_q     <= 1'b0;
      fetch_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      fault_code_q <= fault_code_d;
      mem_we_q     <= mem_we_d;
      fetch_busy_q <= fetch_busy_d;
    end
  end

  // Reset drops an in-flight fetch immediately even with run held high.
  assign fetch_req  = fetch_req_s && !rst;
  assign fetch_addr = pc_q;
  assign instr      = instr_q;
  assign alu_en     = alu_en_s;
  assign rf_we      = rf_we_s;
  assign flags_we   = flags_we_s;
  assign mem_req    = mem_req_s;
  assign mem_we     = mem_req_s && mem_we_q;
  assign pc         = pc_q;
  assign retire     = retire_s;
  assign idle       = idle_s;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: fetch/decode/exec timing, loads, stores,
// branches, PC wrap, undefined-instruction and handshake timeout faults.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk;
  logic        rst;
  logic        run;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic [15:0] instr;
  logic [4:0]  dec_uop;
  logic        dec_explose;
  logic        alu_en;
  logic        rf_we;
  logic        flags_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        retire;
  logic        idle;
  logic        fault;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_errors = 0;

  core_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .fetch_data   (fetch_data),
    .instr        (instr),
    .dec_uop      (dec_uop),
    .dec_explose  (dec_explose),
    .alu_en       (alu_en),
    .rf_we        (rf_we),
    .flags_we     (flags_we),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .retire       (retire),
    .idle         (idle),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a fetch answered in the same cycle; returns in DECODE.
  task automatic fetch_go(input logic [15:0] data, input logic [4:0] uop);
    run        = 1'b1;
    fetch_ack  = 1'b1;
    fetch_data = data;
    dec_uop    = uop;
    tick();
    fetch_ack  = 1'b0;
  endtask

  task automatic do_branch(input logic taken, input logic [31:0] target, input logic [31:0] exp_pc);
    branch_taken  = taken;
    branch_target = target;
    fetch_go(16'hD000, UOP_NOP);
    tick();
    check_eq("br_retire", {31'd0, retire}, 32'd1);
    tick();
    check_eq("br_pc", pc, exp_pc);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; run = 1'b0; fetch_ack = 1'b0; fetch_data = 16'h0000;
    dec_uop = UOP_NOP; dec_explose = 1'b0; mem_ack = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0000_0000;
    #12;
    check_eq("rst_pc", pc, 32'h0000_0000);
    check_eq("rst_instr", {16'd0, instr}, 32'd0);
    check_eq("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    check_eq("rst_fault", {29'd0, fault, fault_code}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_run0", {30'd0, idle, fetch_req}, 32'h2);
    tick();

    // ADD: 3-cycle instruction, PC 0 -> 2
    run = 1'b1; fetch_ack = 1'b1; fetch_data = 16'h1888; dec_uop = UOP_ADD;
    #1;
    check_eq("add_fetch", {fetch_addr[30:0], fetch_req}, 32'h1);
    tick();
    fetch_ack = 1'b0;
    mem_ack   = 1'b1;
    #1;
    check_eq("add_decode", {instr, 13'd0, alu_en, mem_req, retire}, {16'h1888, 16'h0000});
    mem_ack = 1'b0;
    tick();
    check_eq("add_exec", {28'd0, alu_en, rf_we, flags_we, retire}, 32'hF);
    check_eq("add_pc_exec", pc, 32'h0000_0000);
    tick();
    check_eq("add_pc_next", pc, 32'h0000_0002);
    check_eq("add_refetch", {30'd0, fetch_req, retire}, 32'h2);

    // Dropping run mid-request keeps the fetch alive
    tick();
    run = 1'b0;
    #1;
    check_eq("run_drop_req", {30'd0, fetch_req, idle}, 32'h2);

    // LDR: ack in the 5th MEM cycle (4 wait cycles) lands on expiry and wins
    fetch_go(16'h6808, UOP_LDR);
    run = 1'b0;
    #1;
    check_eq("ldr_instr", {16'd0, instr}, 32'h6808);
    tick();
    check_eq("ldr_exec", {29'd0, alu_en, rf_we, retire}, 32'h4);
    tick();
    check_eq("ldr_mem", {29'd0, mem_req, mem_we, retire}, 32'h4);
    tick(); tick(); tick(); tick();
    mem_ack = 1'b1;
    #1;
    check_eq("ldr_ack_expiry", {28'd0, mem_req, rf_we, retire, fault}, 32'h8);
    tick();
    mem_ack = 1'b0;
    #1;
    check_eq("ldr_wb", {29'd0, mem_req, rf_we, retire}, 32'h3);
    check_eq("ldr_wb_pc", pc, 32'h0000_0002);
    tick();
    check_eq("ldr_pc", pc, 32'h0000_0004);
    check_eq("ldr_idle", {30'd0, idle, fault}, 32'h2);

    // STR: 4-cycle minimum
    fetch_go(16'h6008, UOP_STR);
    tick();
    tick();
    mem_ack = 1'b1;
    #1;
    check_eq("str_mem", {29'd0, mem_req, mem_we, retire}, 32'h7);
    tick();
    mem_ack = 1'b0;
    check_eq("str_pc", pc, 32'h0000_0006);

    // Branches and PC wrap
    do_branch(1'b1, 32'h0000_0101, 32'h0000_0100);
    do_branch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_branch(1'b0, 32'h0000_1234, 32'h0000_0000);

    // CMP: flags only
    fetch_go(16'h4288, UOP_CMP);
    tick();
    check_eq("cmp_exec", {28'd0, alu_en, rf_we, flags_we, retire}, 32'hB);
    tick();
    check_eq("cmp_pc", pc, 32'h0000_0002);

    // Undefined instruction
    dec_explose = 1'b1;
    fetch_go(16'hE000, UOP_NOP);
    tick();
    check_eq("undef_exec", {28'd0, alu_en, rf_we, flags_we, retire}, 32'h0);
    tick();
    check_eq("undef_fault", {29'd0, fault, fault_code}, 32'h5);
    check_eq("undef_pc", pc, 32'h0000_0002);
    tick(); tick();
    check_eq("undef_sticky", {28'd0, fault, fetch_req, fault_code}, 32'h9);
    dec_explose = 1'b0;

    // Fetch timeout: ack never comes
    rst = 1'b1;
    run = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check_eq("fto_req", {31'd0, fetch_req}, 32'd1);
    tick(); tick(); tick(); tick();
    check_eq("fto_expiry", {30'd0, fetch_req, fault}, 32'h2);
    tick();
    check_eq("fto_fault", {28'd0, fault, fetch_req, fault_code}, 32'hA);
    tick(); tick();
    check_eq("fto_sticky", {29'd0, fault, fault_code}, 32'h6);
    check_eq("fto_pc", pc, 32'h0000_0000);

    // Mem timeout on a store
    rst = 1'b1;
    #1;
    rst = 1'b0;
    fetch_go(16'h6008, UOP_STR);
    tick();
    tick();
    tick(); tick(); tick(); tick();
    check_eq("mto_expiry", {30'd0, mem_req, fault}, 32'h2);
    tick();
    check_eq("mto_fault", {28'd0, fault, mem_req, fault_code}, 32'hB);

    // Reset while a load waits in MEM
    rst = 1'b1;
    #1;
    rst = 1'b0;
    fetch_go(16'h6808, UOP_LDR);
    tick();
    tick();
    check_eq("mrst_pre", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mrst_reqs", {30'd0, fetch_req, mem_req}, 32'h0);
    check_eq("mrst_pc", pc, 32'h0000_0000);
    rst = 1'b0;
    #1;
    check_eq("mrst_fetch", {30'd0, fetch_req, fault}, 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
